cfg_cmd_arbiter: RTL and testbench

Command front-end for the trigger configuration register file. It accepts 4-word command frames from two independent telecommand sources (primary and backup link) over valid/ready word streams. Sources are arbitrated round-robin at frame boundaries, and each frame is checked for header, checksum, address range and inter-word timeout. Each accepted frame becomes exactly one single-cycle write strobe (`wr_out`/`wr_addr_out`/`wr_data_out`) feeding the configuration register block.

---
 rtl/cfg_cmd_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_cfg_cmd_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_cmd_arbiter.sv
// Two-source round-robin command front-end: validates 4-word frames and issues one config write per good frame.
// Optional macro CFG_ADDR_RANGE_CHK_EN adds an address-window check (8'h02..8'h15) in CHECK.
module cfg_cmd_arbiter #(
  parameter logic [15:0] HEADER      = 16'hEB90,
  parameter int          TIMEOUT_CYC = 1000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        a_valid_in,
  input  logic [15:0] a_data_in,
  output logic        a_ready_out,
  input  logic        b_valid_in,
  input  logic [15:0] b_data_in,
  output logic        b_ready_out,
  output logic        wr_out,
  output logic [7:0]  wr_addr_out,
  output logic [15:0] wr_data_out,
  output logic        busy_out,
  output logic        grant_out,
  output logic [15:0] frame_ok_cnt_out,
  output logic [15:0] frame_err_cnt_out,
  output logic [2:0]  err_code_out
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_RX, S_CHECK, S_WRITE, S_ERR} state_t;

  state_t         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic [1:0]     idx_q, idx_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [2:0]     pend_code_q, pend_code_d;
  logic [2:0]     err_code_q, err_code_d;
  logic [15:0]    ok_cnt_q, ok_cnt_d;
  logic [15:0]    err_cnt_q, err_cnt_d;
  logic [7:0]     wr_addr_q, wr_addr_d;
  logic [15:0]    wr_data_q, wr_data_d;
  logic [15:0]    sum_q, sum_d;
  logic [15:0]    w1_q, w1_d;
  logic [15:0]    w2_q, w2_d;
  logic [15:0]    chk_q, chk_d;

  logic           sel_valid;
  logic [15:0]    sel_data;
  logic           acc;
  logic           addr_bad;

  assign sel_valid = last_grant_q ? b_valid_in : a_valid_in;
  assign sel_data  = last_grant_q ? b_data_in  : a_data_in;
  assign acc       = (state_q == S_RX) && sel_valid;

`ifdef CFG_ADDR_RANGE_CHK_EN
  assign addr_bad = (w1_q[7:0] < 8'h02) || (w1_q[7:0] > 8'h15);
`else
  assign addr_bad = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    idx_d        = idx_q;
    tmo_d        = tmo_q;
    pend_code_d  = pend_code_q;
    err_code_d   = err_code_q;
    ok_cnt_d     = ok_cnt_q;
    err_cnt_d    = err_cnt_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    sum_d        = sum_q;
    w1_d         = w1_q;
    w2_d         = w2_q;
    chk_d        = chk_q;
    case (state_q)
      S_IDLE: begin
        if (a_valid_in || b_valid_in) begin
          last_grant_d = (a_valid_in && b_valid_in) ? ~last_grant_q : b_valid_in;
          state_d      = S_RX;
          idx_d        = 2'd0;
          tmo_d        = '0;
        end
      end
      S_RX: begin
        if (acc) begin
          tmo_d = '0;
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0: begin
              sum_d = sel_data;
              if (sel_data != HEADER) begin
                pend_code_d = 3'd1;
                state_d     = S_ERR;
              end
            end
            2'd1: begin
              w1_d  = sel_data;
              sum_d = sum_q + sel_data;
            end
            2'd2: begin
              w2_d  = sel_data;
              sum_d = sum_q + sel_data;
            end
            default: begin
              chk_d   = sel_data;
              state_d = S_CHECK;
            end
          endcase
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          // The granted source went silent mid-frame (or never started): drop the partial frame.
          pend_code_d = 3'd3;
          state_d     = S_ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_CHECK: begin
        if ((w1_q[15:8] != 8'h00) || (sum_q != chk_q)) begin
          pend_code_d = 3'd2;
          state_d     = S_ERR;
        end else if (addr_bad) begin
          pend_code_d = 3'd4;
          state_d     = S_ERR;
        end else begin
          wr_addr_d = w1_q[7:0];
          wr_data_d = w2_q;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        ok_cnt_d   = ok_cnt_q + 16'd1;
        err_code_d = 3'd0;
        state_d    = S_IDLE;
      end
      S_ERR: begin
        err_cnt_d  = err_cnt_q + 16'd1;
        err_code_d = pend_code_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      idx_q        <= 2'd0;
      tmo_q        <= '0;
      pend_code_q  <= 3'd0;
      err_code_q   <= 3'd0;
      ok_cnt_q     <= 16'd0;
      err_cnt_q    <= 16'd0;
      wr_addr_q    <= 8'd0;
      wr_data_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      pend_code_q  <= pend_code_d;
      err_code_q   <= err_code_d;
      ok_cnt_q     <= ok_cnt_d;
      err_cnt_q    <= err_cnt_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  // Frame word holding registers carry no reset; they are only read after being loaded in RX.
  always_ff @(posedge clk_in) begin
    sum_q <= sum_d;
    w1_q  <= w1_d;
    w2_q  <= w2_d;
    chk_q <= chk_d;
  end

  assign a_ready_out       = (state_q == S_RX) && !last_grant_q;
  assign b_ready_out       = (state_q == S_RX) &&  last_grant_q;
  assign wr_out            = (state_q == S_WRITE);
  assign wr_addr_out       = wr_addr_q;
  assign wr_data_out       = wr_data_q;
  assign busy_out          = (state_q != S_IDLE);
  assign grant_out         = last_grant_q;
  assign frame_ok_cnt_out  = ok_cnt_q;
  assign frame_err_cnt_out = err_cnt_q;
  assign err_code_out      = err_code_q;

endmodule

// File: tb/tb_cfg_cmd_arbiter.sv
// Scoreboard bench for cfg_cmd_arbiter: directed frames push expected writes/errors, a monitor process checks them.
module tb_cfg_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid;
  logic [15:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        wr;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy, grant;
  logic [15:0] ok_cnt, err_cnt;
  logic [2:0]  err_code;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    bit          is_err;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [2:0]  code;
    bit          grant;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  cfg_cmd_arbiter dut (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
    .a_valid_in        (a_valid),
    .a_data_in         (a_data),
    .a_ready_out       (a_ready),
    .b_valid_in        (b_valid),
    .b_data_in         (b_data),
    .b_ready_out       (b_ready),
    .wr_out            (wr),
    .wr_addr_out       (wr_addr),
    .wr_data_out       (wr_data),
    .busy_out          (busy),
    .grant_out         (grant),
    .frame_ok_cnt_out  (ok_cnt),
    .frame_err_cnt_out (err_cnt),
    .err_code_out      (err_code)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [7:0] addr, input logic [15:0] data, input bit g);
    exp_t e;
    e.is_err = 1'b0; e.addr = addr; e.data = data; e.code = 3'd0; e.grant = g;
    sb.push_back(e);
  endtask

  task automatic exp_err(input logic [2:0] code, input bit g);
    exp_t e;
    e.is_err = 1'b1; e.addr = 8'h00; e.data = 16'h0000; e.code = code; e.grant = g;
    sb.push_back(e);
  endtask

  task automatic monitor();
    int          exp_ok  = 0;
    int          exp_er  = 0;
    logic [15:0] prev_er = 16'h0;
    bit          ok_next = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_ok = 0; exp_er = 0; prev_er = 16'h0; ok_next = 1'b0;
      end else begin
        if (ok_next) begin
          chk("ok_cnt_after_write", ok_cnt, exp_ok);
          chk("err_code_after_write", err_code, 0);
          ok_next = 1'b0;
        end
        if (wr) begin
          if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL wr_unexpected: got write addr=%0h data=%0h expected no write", wr_addr, wr_data);
          end else begin
            e = sb.pop_front();
            chk("event_kind_write", 0, e.is_err);
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.data);
            chk("grant_at_write", grant, e.grant);
            exp_ok++;
            ok_next = 1'b1;
          end
        end
        if (err_cnt != prev_er) begin
          exp_er++;
          chk("err_cnt", err_cnt, exp_er);
          if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL err_unexpected: got error code %0d expected no error", err_code);
          end else begin
            e = sb.pop_front();
            chk("event_kind_err", 1, e.is_err);
            chk("err_code", err_code, e.code);
            chk("grant_at_err", grant, e.grant);
          end
        end
        prev_er = err_cnt;
      end
    end
  endtask

  task automatic send_word(input bit src, input logic [15:0] w);
    bit done = 1'b0;
    if (src) begin b_valid = 1'b1; b_data = w; end
    else     begin a_valid = 1'b1; a_data = w; end
    for (int n = 0; n < 2000 && !done; n++) begin
      @(negedge clk);
      if (src ? b_ready : a_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (src) b_valid = 1'b0; else a_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL handshake_timeout: src=%0d word=%0h got no ready expected ready", src, w);
    end
  endtask

  task automatic send_frame(input bit src, input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3);
    send_word(src, w0);
    send_word(src, w1);
    send_word(src, w2);
    send_word(src, w3);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while (busy && n < 1500) begin
      @(negedge clk);
      n++;
    end
    chk(nm, busy, 0);
  endtask

  initial begin
    int viol;
    bit seen;
    rst_n   = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_data  = 16'h0; b_data = 16'h0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wr", wr, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 1);
    chk("rst_ok_cnt", ok_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_ready", {a_ready, b_ready}, 0);
    @(posedge clk); #1;

    // First contest: A wins, B held off for the whole A frame, then B served.
    exp_wr(8'h03, 16'h0ABC, 1'b0);
    exp_wr(8'h05, 16'h1111, 1'b1);
    viol = 0;
    seen = 1'b0;
    fork
      send_frame(1'b0, 16'hEB90, 16'h0003, 16'h0ABC, 16'hF64F);
      send_frame(1'b1, 16'hEB90, 16'h0005, 16'h1111, 16'hFCA6);
      begin
        for (int n = 0; n < 60 && !seen; n++) begin
          @(negedge clk);
          if (b_ready) viol++;
          if (wr) seen = 1'b1;
        end
      end
    join
    chk("b_ready_low_during_a_frame", viol, 0);
    chk("a_frame_write_seen", seen, 1);
    wait_idle("idle_after_ab");

    // Basic A frame.
    exp_wr(8'h04, 16'h00C5, 1'b0);
    send_frame(1'b0, 16'hEB90, 16'h0004, 16'h00C5, 16'hEC59);
    wait_idle("idle_after_basic");

    // Bad checksum.
    exp_err(3'd2, 1'b0);
    send_frame(1'b0, 16'hEB90, 16'h0010, 16'h1234, 16'h0000);
    wait_idle("idle_after_badsum");

    // Bad header: one word consumed, then a good frame goes through.
    exp_err(3'd1, 1'b0);
    send_word(1'b0, 16'h1234);
    wait_idle("idle_after_badhdr");
    exp_wr(8'h07, 16'hBEEF, 1'b0);
    send_frame(1'b0, 16'hEB90, 16'h0007, 16'hBEEF, 16'hAA86);
    wait_idle("idle_after_recover");

    // Non-zero upper byte in W1 is a checksum-class failure even with a matching sum.
    exp_err(3'd2, 1'b0);
    send_frame(1'b0, 16'hEB90, 16'h0104, 16'h0000, 16'hEC94);
    wait_idle("idle_after_w1hi");

    // Upper edge of the address window.
    exp_wr(8'h15, 16'h0001, 1'b0);
    send_frame(1'b0, 16'hEB90, 16'h0015, 16'h0001, 16'hEBA6);
    wait_idle("idle_after_addr15");

    // Address 0x20.
`ifdef CFG_ADDR_RANGE_CHK_EN
    exp_err(3'd4, 1'b0);
`else
    exp_wr(8'h20, 16'h5555, 1'b0);
`endif
    send_frame(1'b0, 16'hEB90, 16'h0020, 16'h5555, 16'h4105);
    wait_idle("idle_after_addr20");

    // Stall after W1.
    exp_err(3'd3, 1'b0);
    send_word(1'b0, 16'hEB90);
    send_word(1'b0, 16'h0004);
    @(negedge clk);
    chk("a_ready_during_stall", a_ready, 1);
    wait_idle("idle_after_timeout");
    chk("a_ready_after_timeout", a_ready, 0);

    // Reset while W2 is offered.
    send_word(1'b0, 16'hEB90);
    send_word(1'b0, 16'h0006);
    a_data  = 16'h2222;
    a_valid = 1'b1;
    @(negedge clk);
    rst_n   = 1'b0;
    a_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ok_cnt", ok_cnt, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_grant", grant, 1);
    chk("midrst_wr_addr", wr_addr, 0);
    repeat (5) @(negedge clk);
    chk("midrst_no_activity", {wr, busy}, 0);
    @(posedge clk); #1;
    exp_wr(8'h04, 16'h00C5, 1'b0);
    send_frame(1'b0, 16'hEB90, 16'h0004, 16'h00C5, 16'hEC59);
    wait_idle("idle_after_midrst_frame");

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
